mult8x8_seq_ctrl: RTL
=====================

// Module: mult8x8_seq_ctrl
// PURPOSE
//  Sequential 8x8 multiplier: one shared 4x4 sub-multiplier, one quadrant partial product per cycle.
//  Exact/approximate cell choice is per quadrant; 16-bit result accumulated internally.
//  Valid/ready on both sides; sits between operand producer and result consumer, area-reduced Mult_8x8 variant.
// PARAMETERS
//  QUAD_APPROX  4'b1100  bit q=1 -> quadrant q uses the approximate 4x4 cell (q0=AL*BL, q1=AL*BH, q2=AH*BL, q3=AH*BH)
//  DROP_BITS    2        approximate cell output = exact 4x4 product with DROP_BITS LSBs forced to 0 (0..4)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   block can accept operands this cycle
//  in_a       in   8   operand A
//  in_b       in   8   operand B
//  mode_mask  in   4   per-request quadrant approx mask (present only with MULT_SEQ_MODE_SEL_EN)
//  out_valid  out  1   result valid, held until taken
//  out_ready  in   1   consumer takes result
//  out_r      out  16  product
//  busy       out  1   high in CALC or DONE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, qcnt=0, acc=0, out_valid=0, out_r=0, busy=0; in_ready=1 once idle.
//  - FSM: IDLE -(in_valid)-> CALC; CALC -(qcnt==3)-> DONE; DONE -(out_ready & !in_valid)-> IDLE;
//    DONE -(out_ready & in_valid)-> CALC (back-to-back accept).
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); accept = in_valid & in_ready.
//  - On accept: register a,b (and mask), acc<=0, qcnt<=0. Inputs ignored outside accept cycles.
//  - CALC, qcnt=q: p=cell(q) 8b; acc <= acc + (p << shift[q]), shift = {0,4,4,8}; qcnt++ (2b, wraps 3->0 on exit).
//  - acc 16b; max sum 0xFE01 -> no overflow; no saturation logic.
//  - Latency: accept in cycle T -> CALC T+1..T+4 -> out_valid=1 from T+5, out_r=acc.
//  - out_r/out_valid stable while out_valid & !out_ready; out_valid clears on handshake unless re-accepted
//    (then next result appears 5 cycles later; out_valid low meanwhile).
//  - Throughput: one result per 5 cycles with out_ready held high and in_valid continuous.
//  - rst_n low mid-CALC/DONE: immediate abort, partial acc discarded, no out_valid.
//  - DROP_BITS=0 or mask=0 -> exact product.
// CONFIGURATION
//  MULT_SEQ_MODE_SEL_EN defined: mode_mask port exists, sampled on accept, overrides QUAD_APPROX for that request.
//  Not defined: no mode_mask port; QUAD_APPROX used for every request.
// STRUCTURE
//  Package mult_seq_pkg: state enum (IDLE, CALC, DONE), QUAD_SHIFT[0:3]={0,4,4,8} constants, quadrant index type.
//  Sub-module mult4x4_cell: combinational 4x4 with approx input and DROP_BITS parameter; one instance only.
//  Top: FSM, qcnt, operand/mask registers, quadrant nibble mux, accumulator.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1 -> out_valid=0, out_r=0, busy=0; after release in_ready=1.
//  2 QUAD_APPROX=0: A=8'hFF,B=8'hFF accepted at T -> out_valid at T+5, out_r=16'hFE01.
//  3 Defaults: A=8'h37,B=8'h5B -> out_r=16'h107D (exact would be 16'h138D).
//  4 Backpressure: out_ready=0 for 3 cycles -> out_r/out_valid hold, in_ready=0; then out_ready=1,in_valid=1
//    -> same-cycle accept, next out_valid exactly 5 cycles later.
//  5 rst_n pulse during CALC qcnt=2 -> IDLE, acc=0, no out_valid; next op A=3,B=5 (QUAD_APPROX=0) -> 16'h000F.
//  6 MULT_SEQ_MODE_SEL_EN, mode_mask=4'b1111, A=B=8'hFF -> out_r=16'hFCE0; mask=0 -> 16'hFE01.

Source files
------------

// File: rtl/mult8x8_seq_ctrl_pkg.sv
// Shared state type, quadrant index type and partial-product placement for the sequential 8x8 multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] quad_idx_t;

  // Left shift of each quadrant product: q0=AL*BL, q1=AL*BH, q2=AH*BL, q3=AH*BH
  localparam logic [3:0] QUAD_SHIFT [0:3] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [15:0] place_pp(input logic [7:0] p, input quad_idx_t q);
    return {8'h00, p} << QUAD_SHIFT[q];
  endfunction

endpackage

// File: rtl/mult8x8_seq_ctrl_if.sv
// Operand/result valid-ready bundle of the sequential multiplier; mode_mask exists only with MULT_SEQ_MODE_SEL_EN.
// The slave modport is the multiplier side, the master modport the producer/consumer side.
interface mult8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        busy;
`ifdef MULT_SEQ_MODE_SEL_EN
  logic [3:0]  mode_mask;

  modport slave (
    input  in_valid, in_a, in_b, mode_mask, out_ready,
    output in_ready, out_valid, out_r, busy
  );
  modport master (
    output in_valid, in_a, in_b, mode_mask, out_ready,
    input  in_ready, out_valid, out_r, busy
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r, busy
  );
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r, busy
  );
`endif
endinterface

// File: rtl/mult8x8_seq_ctrl_cell.sv
// Combinational 4x4 multiplier; in approximate mode the DROP_BITS LSBs of the product are forced to zero.
module mult4x4_cell #(
  parameter int DROP_BITS = 2
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       approx,
  output logic [7:0] p
);

  localparam logic [7:0] DROP_MASK = 8'hFF << DROP_BITS;

  logic [7:0] exact;

  assign exact = {4'h0, a} * {4'h0, b};
  assign p     = approx ? (exact & DROP_MASK) : exact;

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one quadrant per cycle through a shared 4x4 cell, result 5 cycles after accept,
// held until taken; back-to-back accept in DONE. MULT_SEQ_MODE_SEL_EN adds a per-request approx mask.
module mult8x8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter logic [3:0] QUAD_APPROX = 4'b1100,
  parameter int         DROP_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult8x8_seq_ctrl_if.slave    bus
);

  state_t     state;
  quad_idx_t  qcnt;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [15:0] acc;
  logic       out_valid_q;
  logic       busy_q;
  logic [3:0] quad_mask;
  logic       accept;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [7:0] pp;

`ifdef MULT_SEQ_MODE_SEL_EN
  logic [3:0] mask_q;
  assign quad_mask = mask_q;
`else
  assign quad_mask = QUAD_APPROX;
`endif

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = acc;
  assign bus.busy      = busy_q;

  always_comb begin
    a_nib = a_q[3:0];
    b_nib = b_q[3:0];
    case (qcnt)
      2'd0: begin a_nib = a_q[3:0]; b_nib = b_q[3:0]; end
      2'd1: begin a_nib = a_q[3:0]; b_nib = b_q[7:4]; end
      2'd2: begin a_nib = a_q[7:4]; b_nib = b_q[3:0]; end
      default: begin a_nib = a_q[7:4]; b_nib = b_q[7:4]; end
    endcase
  end

  mult4x4_cell #(.DROP_BITS(DROP_BITS)) u_cell (
    .a      (a_nib),
    .b      (b_nib),
    .approx (quad_mask[qcnt]),
    .p      (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      qcnt        <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      acc         <= 16'h0000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULT_SEQ_MODE_SEL_EN
      mask_q      <= QUAD_APPROX;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= CALC;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          acc  <= acc + place_pp(pp, qcnt);
          qcnt <= qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              state <= CALC;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Accept is only possible in IDLE or DONE, so this never collides with the CALC update above
      if (accept) begin
        a_q  <= bus.in_a;
        b_q  <= bus.in_b;
        acc  <= 16'h0000;
        qcnt <= 2'd0;
`ifdef MULT_SEQ_MODE_SEL_EN
        mask_q <= bus.mode_mask;
`endif
      end
    end
  end

endmodule
